// File: rtl/mult_limb_seq_if.sv
// Stream bundle for mult_limb_seq: two operand streams in, one product stream out, plus busy status.
interface mult_limb_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0]   input_a_tdata;
  logic               input_a_tvalid;
  logic               input_a_tready;
  logic [WIDTH-1:0]   input_b_tdata;
  logic               input_b_tvalid;
  logic               input_b_tready;
  logic [2*WIDTH-1:0] output_tdata;
  logic               output_tvalid;
  logic               output_tready;
  logic               busy;

  modport master (
    output input_a_tdata, input_a_tvalid, input input_a_tready,
    output input_b_tdata, input_b_tvalid, input input_b_tready,
    input  output_tdata, output_tvalid, output output_tready,
    input  busy
  );

  modport slave (
    input  input_a_tdata, input_a_tvalid, output input_a_tready,
    input  input_b_tdata, input_b_tvalid, output input_b_tready,
    output output_tdata, output_tvalid, input output_tready,
    output busy
  );
endinterface

// File: rtl/mult_limb_seq.sv
// Sequential WIDTH x WIDTH multiplier built from one LIMB x LIMB multiplier and a 2*WIDTH accumulator.
// Optional MULT_PREREG_EN registers the limb product before the accumulator (adds one PIPE cycle).
module mult_limb_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LIMB  = 32
) (
  input  logic          clk,
  input  logic          rst,
  mult_limb_seq_if.slave bus
);
  localparam int unsigned N  = WIDTH / LIMB;
  localparam int unsigned PW = 2 * LIMB;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, PIPE, OUT} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d, out_q, out_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic             a_rdy, b_rdy;

  logic [LIMB-1:0]  a_limb, b_limb;
  logic [PW-1:0]    prod;
  logic [31:0]      sh;
  logic [AW-1:0]    term, acc_sum;
  logic             last;

  // Limb select and partial product for the current (i, j) pair
  assign a_limb = LIMB'(a_q >> (32'(j_q) * LIMB));
  assign b_limb = LIMB'(b_q >> (32'(i_q) * LIMB));
  assign prod   = PW'(a_limb) * PW'(b_limb);
  assign sh     = (32'(i_q) + 32'(j_q)) * LIMB;
  assign last   = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

`ifdef MULT_PREREG_EN
  logic [PW-1:0] prod_q;
  logic [31:0]   sh_q;
  logic          pv_q;

  // Product staged one cycle; pv_q marks a term pending accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      sh_q   <= '0;
      pv_q   <= 1'b0;
    end else begin
      prod_q <= prod;
      sh_q   <= sh;
      pv_q   <= (state_q == MUL);
    end
  end

  assign term = pv_q ? (AW'(prod_q) << sh_q) : '0;
`else
  assign term = AW'(prod) << sh;
`endif

  assign acc_sum = acc_q + term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    i_d     = i_q;
    j_d     = j_q;
    a_rdy   = 1'b0;
    b_rdy   = 1'b0;
    case (state_q)
      IDLE: begin
        // Cross-coupled readies: a transfer needs both sides valid together
        a_rdy = bus.input_b_tvalid;
        b_rdy = bus.input_a_tvalid;
        if (bus.input_a_tvalid && bus.input_b_tvalid) begin
          a_d     = bus.input_a_tdata;
          b_d     = bus.input_b_tdata;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_sum;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          i_d = IW'(i_q + 1'b1);
        end else begin
          j_d = IW'(j_q + 1'b1);
        end
        if (last) begin
          i_d = '0;
          j_d = '0;
`ifdef MULT_PREREG_EN
          state_d = PIPE;
`else
          out_d   = acc_sum;
          state_d = OUT;
`endif
        end
      end
      PIPE: begin
        acc_d   = acc_sum;
        out_d   = acc_sum;
        state_d = OUT;
      end
      OUT: begin
        if (bus.output_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.input_a_tready = a_rdy;
  assign bus.input_b_tready = b_rdy;
  assign bus.output_tvalid  = (state_q == OUT);
  assign bus.output_tdata   = out_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mult_limb_seq.sv
// Directed bench for mult_limb_seq: 32/16 instance for protocol cases, 64/32 instance for back-to-back.
module tb_mult_limb_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

`ifdef MULT_PREREG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int SPACING = LAT + 2;

  always #5 clk = ~clk;

  mult_limb_seq_if #(.WIDTH(32)) if32 ();
  mult_limb_seq_if #(.WIDTH(64)) if64 ();

  mult_limb_seq #(.WIDTH(32), .LIMB(16)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  mult_limb_seq #(.WIDTH(64), .LIMB(32)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the 32-bit product, counting edges since the accept edge
  task automatic wait_out32(input string tag);
    int cyc;
    cyc = 0;
    while (!if32.output_tvalid && cyc < 50) begin
      step();
      cyc++;
    end
    check(tag, 128'(cyc), 128'(LAT));
  endtask

  logic [63:0]  pa [4];
  logic [63:0]  pb [4];
  logic [127:0] pe [4];

  initial begin
    int seen, sent, got, last_cyc;
    logic xfer;

    pa[0] = 64'hFFFF_FFFF_FFFF_FFFF; pb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pe[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    pa[1] = 64'h0000_0001_0000_0001; pb[1] = 64'h0000_0001_0000_0001;
    pe[1] = 128'h0000_0000_0000_0001_0000_0002_0000_0001;
    pa[2] = 64'h0000_0001_2345_6789; pb[2] = 64'h10;
    pe[2] = 128'h12_3456_7890;
    pa[3] = 64'h8000_0000_0000_0000; pb[3] = 64'h2;
    pe[3] = 128'h1_0000_0000_0000_0000;

    rst = 1'b1;
    if32.input_a_tdata = '0; if32.input_a_tvalid = 1'b0;
    if32.input_b_tdata = '0; if32.input_b_tvalid = 1'b0;
    if32.output_tready = 1'b1;
    if64.input_a_tdata = '0; if64.input_a_tvalid = 1'b0;
    if64.input_b_tdata = '0; if64.input_b_tvalid = 1'b0;
    if64.output_tready = 1'b1;
    step(); step(); step();

    // Reset state
    check("rst_a_tready", 128'(if32.input_a_tready), 128'(0));
    check("rst_b_tready", 128'(if32.input_b_tready), 128'(0));
    check("rst_tvalid",   128'(if32.output_tvalid),  128'(0));
    check("rst_tdata",    128'(if32.output_tdata),   128'(0));
    check("rst_busy",     128'(if32.busy),           128'(0));
    rst = 1'b0;
    step();

    // Basic product, latency and single-cycle valid
    if32.input_a_tdata = 32'd1343301346;
    if32.input_b_tdata = 32'd2955067115;
    if32.input_a_tvalid = 1'b1; if32.input_b_tvalid = 1'b1;
    #1;
    check("t1_a_tready", 128'(if32.input_a_tready), 128'(1));
    step();
    if32.input_a_tvalid = 1'b0; if32.input_b_tvalid = 1'b0;
    check("t1_busy", 128'(if32.busy), 128'(1));
    wait_out32("t1_latency");
    check("t1_data", 128'(if32.output_tdata), 128'(64'd3969545633099836790));
    step();
    check("t1_pulse", 128'(if32.output_tvalid), 128'(0));
    check("t1_idle",  128'(if32.busy), 128'(0));

    // Full carry chain with output stalled 6 cycles
    if32.output_tready = 1'b0;
    if32.input_a_tdata = 32'hFFFF_FFFF;
    if32.input_b_tdata = 32'hFFFF_FFFF;
    if32.input_a_tvalid = 1'b1; if32.input_b_tvalid = 1'b1;
    #1;
    step();
    wait_out32("t2_latency");
    for (int k = 0; k < 6; k++) begin
      check("t2_hold_valid", 128'(if32.output_tvalid), 128'(1));
      check("t2_hold_data",  128'(if32.output_tdata),  128'(64'hFFFF_FFFE_0000_0001));
      check("t2_a_tready",   128'(if32.input_a_tready), 128'(0));
      check("t2_b_tready",   128'(if32.input_b_tready), 128'(0));
      step();
    end
    if32.input_a_tvalid = 1'b0; if32.input_b_tvalid = 1'b0;
    if32.output_tready = 1'b1;
    check("t2_7th_valid", 128'(if32.output_tvalid), 128'(1));
    check("t2_7th_data",  128'(if32.output_tdata),  128'(64'hFFFF_FFFE_0000_0001));
    step();
    check("t2_done_valid", 128'(if32.output_tvalid), 128'(0));
    check("t2_done_busy",  128'(if32.busy), 128'(0));

    // Single-sided valid never transfers
    if32.input_a_tdata = 32'd7;
    if32.input_b_tdata = 32'd9;
    if32.input_a_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_a_tready", 128'(if32.input_a_tready), 128'(0));
      check("t3_busy",     128'(if32.busy), 128'(0));
    end
    if32.input_b_tvalid = 1'b1;
    #1;
    check("t3_pair_ready", 128'(if32.input_a_tready), 128'(1));
    step();
    if32.input_a_tvalid = 1'b0; if32.input_b_tvalid = 1'b0;
    check("t3_busy_after", 128'(if32.busy), 128'(1));
    wait_out32("t3_latency");
    check("t3_data", 128'(if32.output_tdata), 128'(64'd63));
    step();

    // Reset in MUL abandons the operation
    if32.input_a_tdata = 32'h0001_2345;
    if32.input_b_tdata = 32'h0000_6789;
    if32.input_a_tvalid = 1'b1; if32.input_b_tvalid = 1'b1;
    #1;
    step();
    if32.input_a_tvalid = 1'b0; if32.input_b_tvalid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_tvalid", 128'(if32.output_tvalid), 128'(0));
    check("t4_tdata",  128'(if32.output_tdata),  128'(0));
    check("t4_busy",   128'(if32.busy), 128'(0));
    check("t4_a_tready", 128'(if32.input_a_tready), 128'(0));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (if32.output_tvalid) seen++;
    end
    check("t4_no_output", 128'(seen), 128'(0));
    if32.input_a_tdata = 32'd3;
    if32.input_b_tdata = 32'd5;
    if32.input_a_tvalid = 1'b1; if32.input_b_tvalid = 1'b1;
    #1;
    step();
    if32.input_a_tvalid = 1'b0; if32.input_b_tvalid = 1'b0;
    wait_out32("t4_latency");
    check("t4_data", 128'(if32.output_tdata), 128'(64'd15));
    step();

    // Back-to-back on the 64/32 instance
    sent = 0; got = 0; last_cyc = -1;
    if64.input_a_tdata = pa[0]; if64.input_b_tdata = pb[0];
    if64.input_a_tvalid = 1'b1; if64.input_b_tvalid = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      #1;
      xfer = if64.input_a_tready && if64.input_a_tvalid && if64.input_b_tvalid;
      step();
      if (xfer) begin
        sent++;
        if (sent < 4) begin
          if64.input_a_tdata = pa[sent]; if64.input_b_tdata = pb[sent];
        end else begin
          if64.input_a_tvalid = 1'b0; if64.input_b_tvalid = 1'b0;
        end
      end
      if (if64.output_tvalid) begin
        check("b2b_data", if64.output_tdata, pe[got]);
        if (got > 0) check("b2b_spacing", 128'(cyc - last_cyc), 128'(SPACING));
        last_cyc = cyc;
        got++;
      end
    end
    check("b2b_count", 128'(got), 128'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
